// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse packet tracker: frames 3-byte movement packets and keeps a clamped
// absolute cursor position plus button state, with a per-packet idle timeout.
module ps2_mouse_tracker #(
  parameter int X_MAX       = 63,
  parameter int Y_MAX       = 63,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic signed [8:0] PS2_Xdata,
  output logic signed [8:0] PS2_Ydata,
  output logic              btn_left,
  output logic              btn_right,
  output logic              pkt_valid,
  output logic              sync_err,
  output logic [1:0]        o_dbg_state
);

  // Handshake: a byte is consumed on any cycle rx_valid is high, except in UPDATE.
  typedef enum logic [1:0] {WAIT_B0, WAIT_B1, WAIT_B2, UPDATE} state_t;

  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0]     IDLE_LIM = CW'(TIMEOUT_CYC - 1);
  localparam logic signed [10:0] X_LIM   = 11'(X_MAX);
  localparam logic signed [10:0] Y_LIM   = 11'(Y_MAX);

  state_t            r_state, w_state_nxt;
  logic [CW-1:0]     r_idle;
  logic [5:0]        r_stat;   // {y_ovf, x_ovf, y_sign, x_sign, right, left}
  logic [7:0]        r_dx, r_dy;

  logic              w_counting, w_timeout, w_framing;
  logic signed [10:0] w_dx, w_dy, w_sum_x, w_sum_y;
  logic signed [8:0] w_x_nxt, w_y_nxt;
  logic              w_bl_nxt, w_br_nxt, w_pkt_nxt, w_err_nxt;

  assign w_counting = (r_state == WAIT_B1) || (r_state == WAIT_B2);
  // A byte arriving on the timeout cycle takes priority over the timeout.
  assign w_timeout  = w_counting && !rx_valid && (r_idle == IDLE_LIM);
  assign w_framing  = (r_state == WAIT_B0) && rx_valid && !rx_data[3];

  always_ff @(posedge clk) begin
    if (reset) r_state <= WAIT_B0;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      WAIT_B0: if (rx_valid && rx_data[3]) w_state_nxt = WAIT_B1;
      WAIT_B1: if (rx_valid) w_state_nxt = WAIT_B2;
               else if (w_timeout) w_state_nxt = WAIT_B0;
      WAIT_B2: if (rx_valid) w_state_nxt = UPDATE;
               else if (w_timeout) w_state_nxt = WAIT_B0;
      UPDATE:  w_state_nxt = WAIT_B0;
      default: w_state_nxt = WAIT_B0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idle <= '0;
      r_stat <= '0;
      r_dx   <= '0;
      r_dy   <= '0;
    end else begin
      if (rx_valid && (r_state == WAIT_B0) && rx_data[3]) r_stat <= {rx_data[7:4], rx_data[1:0]};
      if (rx_valid && (r_state == WAIT_B1)) r_dx <= rx_data;
      if (rx_valid && (r_state == WAIT_B2)) r_dy <= rx_data;
      if (w_counting && !rx_valid && !w_timeout) r_idle <= r_idle + CW'(1);
      else                                       r_idle <= '0;
    end
  end

  // Overflowed axes contribute no motion; Y is flipped to screen orientation.
  always_comb begin
    w_dx    = r_stat[4] ? 11'sd0 : {{3{r_stat[2]}}, r_dx};
    w_dy    = r_stat[5] ? 11'sd0 : {{3{r_stat[3]}}, r_dy};
    w_sum_x = {{2{PS2_Xdata[8]}}, PS2_Xdata} + w_dx;
    w_sum_y = {{2{PS2_Ydata[8]}}, PS2_Ydata} - w_dy;
    w_x_nxt   = PS2_Xdata;
    w_y_nxt   = PS2_Ydata;
    w_bl_nxt  = btn_left;
    w_br_nxt  = btn_right;
    w_pkt_nxt = (r_state == UPDATE);
    w_err_nxt = w_framing || w_timeout;
    if (r_state == UPDATE) begin
      if (w_sum_x < 11'sd0)      w_x_nxt = 9'sd0;
      else if (w_sum_x > X_LIM)  w_x_nxt = X_LIM[8:0];
      else                       w_x_nxt = w_sum_x[8:0];
      if (w_sum_y < 11'sd0)      w_y_nxt = 9'sd0;
      else if (w_sum_y > Y_LIM)  w_y_nxt = Y_LIM[8:0];
      else                       w_y_nxt = w_sum_y[8:0];
      w_bl_nxt = r_stat[0];
      w_br_nxt = r_stat[1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      PS2_Xdata <= 9'(X_MAX >> 1);
      PS2_Ydata <= 9'(Y_MAX >> 1);
      btn_left  <= 1'b0;
      btn_right <= 1'b0;
      pkt_valid <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      PS2_Xdata <= w_x_nxt;
      PS2_Ydata <= w_y_nxt;
      btn_left  <= w_bl_nxt;
      btn_right <= w_br_nxt;
      pkt_valid <= w_pkt_nxt;
      sync_err  <= w_err_nxt;
    end
  end

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Bench for ps2_mouse_tracker: directed packet scenarios followed by random
// packets, compared against an arithmetic cursor model.
module tb_ps2_mouse_tracker;
  localparam int X_MAX = 63;
  localparam int Y_MAX = 63;
  localparam int TMO   = 100;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic signed [8:0] PS2_Xdata, PS2_Ydata;
  logic              btn_left, btn_right, pkt_valid, sync_err;
  logic [1:0]        dbg_state;

  int n_pass = 0, n_total = 0;
  int mx, my, mbl, mbr;
  int err_seen = 0, overlap = 0, consec = 0;
  logic prev_pkt = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  ps2_mouse_tracker #(.X_MAX(X_MAX), .Y_MAX(Y_MAX), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .PS2_Xdata(PS2_Xdata), .PS2_Ydata(PS2_Ydata),
    .btn_left(btn_left), .btn_right(btn_right),
    .pkt_valid(pkt_valid), .sync_err(sync_err), .o_dbg_state(dbg_state)
  );

  always @(negedge clk) begin
    if (sync_err) err_seen++;
    if (sync_err && pkt_valid) overlap++;
    if (pkt_valid && prev_pkt) consec++;
    prev_pkt = pkt_valid;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string tag, input logic signed [31:0] obs, input int exp);
    n_total++;
    assert (obs === 32'(exp)) n_pass++;
    else $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
  endtask

  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic void model_pkt(input logic [7:0] s, input logic [7:0] d1, input logic [7:0] d2);
    int dx, dy;
    dx = s[6] ? 0 : (s[4] ? int'(d1) - 256 : int'(d1));
    dy = s[7] ? 0 : (s[5] ? int'(d2) - 256 : int'(d2));
    mx  = clampi(mx + dx, X_MAX);
    my  = clampi(my - dy, Y_MAX);
    mbl = int'(s[0]);
    mbr = int'(s[1]);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mx = X_MAX >> 1; my = Y_MAX >> 1; mbl = 0; mbr = 0;
  endtask

  // Called right after the third byte was sampled: UPDATE cycle, then outputs.
  task automatic finish_check(input string tag);
    chk({tag, "_pkt_early"}, pkt_valid, 0);
    @(negedge clk);
    chk({tag, "_pkt"}, pkt_valid, 1);
    chk({tag, "_x"}, PS2_Xdata, mx);
    chk({tag, "_y"}, PS2_Ydata, my);
    chk({tag, "_bl"}, btn_left, mbl);
    chk({tag, "_br"}, btn_right, mbr);
    @(negedge clk);
    chk({tag, "_pkt_end"}, pkt_valid, 0);
    chk({tag, "_x_hold"}, PS2_Xdata, mx);
  endtask

  task automatic send_packet(input logic [7:0] s, input logic [7:0] d1, input logic [7:0] d2,
                             input int gap, input string tag);
    send_byte(s);
    repeat (gap) @(negedge clk);
    send_byte(d1);
    repeat (gap) @(negedge clk);
    send_byte(d2);
    model_pkt(s, d1, d2);
    finish_check(tag);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int k, err0, xb, yb;
    logic found;
    logic [7:0] s, d1, d2, b;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    mx = X_MAX >> 1; my = Y_MAX >> 1; mbl = 0; mbr = 0;
    chk("rst_x", PS2_Xdata, 31);
    chk("rst_y", PS2_Ydata, 31);
    chk("rst_bl", btn_left, 0);
    chk("rst_br", btn_right, 0);
    chk("rst_pkt", pkt_valid, 0);
    chk("rst_err", sync_err, 0);
    chk("rst_state", dbg_state, 0);

    send_packet(8'h09, 8'h05, 8'h03, 0, "basic");
    chk("basic_x36", PS2_Xdata, 36);
    chk("basic_y28", PS2_Ydata, 28);
    chk("basic_bl1", btn_left, 1);

    do_reset();
    send_packet(8'h18, 8'h9C, 8'h00, 1, "clamp_lo");
    chk("clamp_lo_x0", PS2_Xdata, 0);
    chk("clamp_lo_y31", PS2_Ydata, 31);
    send_packet(8'h08, 8'h7F, 8'h00, 0, "clamp_hi1");
    send_packet(8'h08, 8'h7F, 8'h00, 2, "clamp_hi2");
    chk("clamp_hi_x63", PS2_Xdata, 63);

    xb = mx;
    yb = my;
    send_packet(8'h48, 8'h20, 8'h10, 0, "ovf");
    chk("ovf_x_hold", PS2_Xdata, xb);
    chk("ovf_y_dec", PS2_Ydata, yb - 16);

    // Framing error in WAIT_B0.
    send_byte(8'h00);
    chk("frame_err", sync_err, 1);
    chk("frame_nopkt", pkt_valid, 0);
    @(negedge clk);
    chk("frame_err_end", sync_err, 0);
    chk("frame_x_hold", PS2_Xdata, mx);
    send_packet(8'h0A, 8'h01, 8'h01, 0, "after_frame");

    // A byte presented during UPDATE must be dropped.
    send_byte(8'h08);
    send_byte(8'h01);
    @(negedge clk);
    rx_data = 8'h00; rx_valid = 1'b1;
    @(negedge clk);
    rx_data = 8'h08;
    @(negedge clk);
    rx_valid = 1'b0;
    model_pkt(8'h08, 8'h01, 8'h00);
    chk("upd_ign_pkt", pkt_valid, 1);
    chk("upd_ign_x", PS2_Xdata, mx);
    send_byte(8'h01);
    chk("upd_ign_err", sync_err, 1);
    chk("upd_ign_state", dbg_state, 0);

    // Idle timeout mid-packet.
    send_byte(8'h08);
    k = 0; found = 1'b0;
    while (k < 3 * TMO && !found) begin
      @(negedge clk);
      k++;
      if (sync_err) found = 1'b1;
    end
    chk("tmo_latency", k, TMO);
    chk("tmo_state", dbg_state, 0);
    send_packet(8'h08, 8'h02, 8'h00, 0, "after_tmo");

    // Byte arriving on the exact timeout cycle is accepted.
    err0 = err_seen;
    send_byte(8'h08);
    repeat (TMO - 2) @(negedge clk);
    send_byte(8'h03);
    chk("win_state", dbg_state, 2);
    send_byte(8'h00);
    model_pkt(8'h08, 8'h03, 8'h00);
    finish_check("win");
    chk("win_no_err", err_seen, err0);

    // Reset in the middle of a packet.
    send_byte(8'h08);
    send_byte(8'h05);
    do_reset();
    send_packet(8'h08, 8'h01, 8'h00, 0, "mid_rst");
    chk("mid_rst_x32", PS2_Xdata, 32);
    chk("mid_rst_y31", PS2_Ydata, 31);

    // Random packets with occasional framing errors.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        b = 8'($urandom) & 8'hF7;
        send_byte(b);
        chk("rnd_frame_err", sync_err, 1);
      end
      s  = 8'($urandom) | 8'h08;
      d1 = 8'($urandom);
      d2 = 8'($urandom);
      send_packet(s, d1, d2, $urandom_range(0, 6), "rnd");
    end

    repeat (2) @(negedge clk);
    chk("no_overlap", overlap, 0);
    chk("no_consec_pkt", consec, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
